// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
// Includes the state codes, opcode constants, datapath select encodings and per-state Moore control word.
package control_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StWbAlu   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWr   = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJal     = 4'd10,
    StJalr    = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsIllegal
  } instr_cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  // Pure state-decoded outputs; handshake-qualified strobes are added in the top.
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic [1:0] jump;
    logic       reg_write;
    logic       retire;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      StDecode: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      StExecR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_RTYPE;
      end
      StExecI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      StWbAlu: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_ALUOUT;
        c.retire     = 1'b1;
      end
      StMemAddr: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StWbMem: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        c.retire     = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_BRANCH;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ALUOUT;
        c.retire    = 1'b1;
      end
      StJal: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PCSRC_ALUOUT;
        c.jump       = JUMP_JAL;
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.retire     = 1'b1;
      end
      StJalr: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_IMM;
        c.alu_op     = ALU_ADD;
        c.pc_write   = 1'b1;
        c.pc_src     = PCSRC_ALU;
        c.jump       = JUMP_JALR;
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.retire     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory bundle: the controller is the master, the datapath the slave.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             branch;
  logic [1:0]       jump;
  logic             reg_write;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, branch, jump, reg_write, illegal, instr_done, instret, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, branch, jump, reg_write, illegal, instr_done, instret, state
  );
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// Combinational opcode -> instruction class decoder with legality flag.
module opcode_classify
  import control_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic [6:0] opcode_i,
  output instr_cls_e cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o = ClsIllegal;
    case (opcode_i)
      OP_R:      cls_o = ClsR;
      OP_I:      cls_o = ClsI;
      OP_LOAD:   cls_o = ClsLoad;
      OP_STORE:  cls_o = ClsStore;
      OP_BRANCH: cls_o = ClsBranch;
      OP_JAL:    cls_o = ENABLE_JUMP ? ClsJal : ClsIllegal;
      OP_JALR:   cls_o = ENABLE_JUMP ? ClsJalr : ClsIllegal;
      default:   cls_o = ClsIllegal;
    endcase
  end

  assign legal_o = (cls_o != ClsIllegal);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore main control for the RV32I shared-memory datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalls on mem_ready, counts retirements.
module multicycle_control
  import control_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ENABLE_JUMP   = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] instret_q;
  logic             is_store_q;
  instr_cls_e       cls;
  logic             legal;
  logic             rdy;
  logic             in_fetch;
  logic             retire;
  logic             run;

  opcode_classify #(
    .ENABLE_JUMP(ENABLE_JUMP)
  ) u_classify (
    .opcode_i(bus.opcode),
    .cls_o   (cls),
    .legal_o (legal)
  );

  assign rdy      = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign in_fetch = (state_q == StFetch);
  assign run      = ~rst;
  assign retire   = ctrl_q.retire | ((state_q == StMemWr) & rdy);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (rdy) state_d = StDecode;
      StDecode: begin
        case (cls)
          ClsR:              state_d = StExecR;
          ClsI:              state_d = StExecI;
          ClsLoad, ClsStore: state_d = StMemAddr;
          ClsBranch:         state_d = StBranch;
          ClsJal:            state_d = StJal;
          ClsJalr:           state_d = StJalr;
          default:           state_d = StFetch;
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StMemAddr:        state_d = is_store_q ? StMemWr : StMemRd;
      StMemRd:          if (rdy) state_d = StWbMem;
      StMemWr:          if (rdy) state_d = StFetch;
      StWbAlu, StWbMem, StBranch, StJal, StJalr: state_d = StFetch;
      default:          state_d = StFetch;
    endcase
  end

  // Control word is registered alongside the state so it always matches ctrl_for(state_q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      ctrl_q     <= ctrl_for(StFetch);
      instret_q  <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_q == StDecode) is_store_q <= (cls == ClsStore);
    end
  end

  // Reset gates everything combinationally so outputs drop without waiting for an edge.
  assign bus.pc_write   = run & (ctrl_q.pc_write | (in_fetch & rdy));
  assign bus.ir_write   = run & in_fetch & rdy;
  assign bus.i_or_d     = run & ctrl_q.i_or_d;
  assign bus.mem_read   = run & ctrl_q.mem_read;
  assign bus.mem_write  = run & ctrl_q.mem_write;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg & {2{run}};
  assign bus.alu_src_a  = ctrl_q.alu_src_a & {2{run}};
  assign bus.alu_src_b  = ctrl_q.alu_src_b & {2{run}};
  assign bus.alu_op     = ctrl_q.alu_op & {2{run}};
  assign bus.pc_src     = ctrl_q.pc_src & {2{run}};
  assign bus.branch     = run & ctrl_q.branch;
  assign bus.jump       = ctrl_q.jump & {2{run}};
  assign bus.reg_write  = run & ctrl_q.reg_write;
  assign bus.illegal    = run & (state_q == StDecode) & ~legal;
  assign bus.instr_done = run & retire;
  assign bus.instret    = instret_q;
  assign bus.state      = state_q;

endmodule
